// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StDrain = 2'd2
  } fetch_state_e;

  localparam int unsigned FetchAddrW = 32;
  localparam int unsigned FetchDataW = 32;

  typedef struct packed {
    logic [FetchAddrW-1:0] pc;
    logic [FetchDataW-1:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP = 32'h0;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory req/ack bus plus the decode-side valid/ready handshake.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              decode_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, decode_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, decode_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; the head entry is read combinationally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned Depth   = 2,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  input  logic   flush,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  entry_t            mem [Depth];
  logic [PtrW-1:0]   wr_ptr;
  logic [PtrW-1:0]   rd_ptr;
  logic [PtrW:0]     count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (PtrW + 1)'(Depth));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;
  assign head    = mem[rd_ptr];

  // Flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
      count <= count + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem read per PC, results buffered for decode.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_stall,
  input  logic              flush,
  output logic              misalign_err,
  output logic [31:0]       fetch_count,
  instr_fetch_unit_if.master bus
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  fetch_state_e state;
  logic         fifo_full;
  logic         fifo_empty;
  logic         push;
  logic         pop;
  entry_t       push_data;
  entry_t       head;

  assign push      = (state == StWait) && bus.imem_ack && !flush;
  assign pop       = !fifo_empty && bus.decode_ready;
  assign push_data = '{pc: bus.imem_addr, instr: bus.imem_rdata};
  assign pc_stall  = (state != StIdle) || fifo_full;

  // Invalid head reads as a NOP at pc 0 rather than stale storage.
  assign bus.instr_valid = !fifo_empty;
  assign bus.instr       = fifo_empty ? DATA_W'(NOP) : head.instr;
  assign bus.instr_pc    = fifo_empty ? '0 : head.pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= StIdle;
      bus.imem_req  <= 1'b0;
      bus.imem_addr <= '0;
      misalign_err  <= 1'b0;
      fetch_count   <= '0;
    end else begin
      misalign_err <= 1'b0;
      case (state)
        StIdle: begin
          if (!flush && !fifo_full) begin
            if (pc_in[1:0] != 2'b00) begin
              misalign_err <= 1'b1;
            end else begin
              bus.imem_addr <= pc_in;
              bus.imem_req  <= 1'b1;
              state         <= StWait;
            end
          end
        end
        StWait: begin
          if (bus.imem_ack) begin
            bus.imem_req <= 1'b0;
            state        <= StIdle;
            if (!flush) fetch_count <= fetch_count + 32'd1;
          end else if (flush) begin
            state <= StDrain;
          end
        end
        StDrain: begin
          // The stale response must still be absorbed before a new request.
          if (bus.imem_ack) begin
            bus.imem_req <= 1'b0;
            state        <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  fetch_fifo #(
    .Depth   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue model.
module tb_instr_fetch_unit;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        pc_stall;
  logic        flush;
  logic        misalign_err;
  logic [31:0] fetch_count;

  instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  instr_fetch_unit #(
    .FIFO_DEPTH (DEPTH),
    .ADDR_W     (32),
    .DATA_W     (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_in        (pc_in),
    .pc_stall     (pc_stall),
    .flush        (flush),
    .misalign_err (misalign_err),
    .fetch_count  (fetch_count),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: one optional outstanding read, whether its data will be dropped, and the buffer.
  bit          m_req;
  bit          m_drop;
  bit          m_mis;
  logic [31:0] m_addr;
  logic [31:0] m_cnt;
  ent_t        q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_req  = 1'b0;
    m_drop = 1'b0;
    m_mis  = 1'b0;
    m_addr = '0;
    m_cnt  = '0;
    q.delete();
  endtask

  task automatic model_step();
    bit   do_push;
    bit   do_pop;
    ent_t e;
    ent_t gone;
    if (!rst_n) begin
      model_reset();
      return;
    end
    do_push = 1'b0;
    do_pop  = (q.size() != 0) && bus.decode_ready;
    e.pc    = m_addr;
    e.instr = bus.imem_rdata;
    m_mis   = 1'b0;
    if (!m_req) begin
      if (!flush && q.size() < DEPTH) begin
        if (pc_in[1:0] != 2'b00) m_mis = 1'b1;
        else begin
          m_req  = 1'b1;
          m_addr = pc_in;
          m_drop = 1'b0;
        end
      end
    end else if (bus.imem_ack) begin
      m_req = 1'b0;
      if (!m_drop && !flush) begin
        do_push = 1'b1;
        m_cnt   = m_cnt + 32'd1;
      end
    end else if (flush) begin
      m_drop = 1'b1;
    end
    if (flush) q.delete();
    else begin
      if (do_pop) gone = q.pop_front();
      if (do_push) q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_req", 64'(bus.imem_req), 64'(m_req));
      chk("imem_addr", 64'(bus.imem_addr), 64'(m_addr));
      chk("pc_stall", 64'(pc_stall), 64'(m_req || (q.size() == DEPTH)));
      chk("misalign_err", 64'(misalign_err), 64'(m_mis));
      chk("fetch_count", 64'(fetch_count), 64'(m_cnt));
      chk("instr_valid", 64'(bus.instr_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
        chk("instr", 64'(bus.instr), 64'(q[0].instr));
        chk("instr_pc", 64'(bus.instr_pc), 64'(q[0].pc));
      end
    end
  end

  // Apply inputs for the next edge, advance the model at that edge, return at the negedge.
  task automatic tick(input logic [31:0] pc, input logic fl, input logic ack,
                      input logic [31:0] rd, input logic dr);
    pc_in            = pc;
    flush            = fl;
    bus.imem_ack     = ack;
    bus.imem_rdata   = rd;
    bus.decode_ready = dr;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, 64'(bus.imem_req), 64'd0);
    chk({tag, "_addr"}, 64'(bus.imem_addr), 64'd0);
    chk({tag, "_valid"}, 64'(bus.instr_valid), 64'd0);
    chk({tag, "_instr"}, 64'(bus.instr), 64'd0);
    chk({tag, "_ipc"}, 64'(bus.instr_pc), 64'd0);
    chk({tag, "_mis"}, 64'(misalign_err), 64'd0);
    chk({tag, "_cnt"}, 64'(fetch_count), 64'd0);
    chk({tag, "_stall"}, 64'(pc_stall), 64'd0);
  endtask

  initial begin
    logic [31:0] rpc;
    logic        rack;
    rst_n            = 1'b0;
    pc_in            = '0;
    flush            = 1'b0;
    bus.imem_ack     = 1'b0;
    bus.imem_rdata   = '0;
    bus.decode_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Basic fetch with one-cycle ack latency.
    tick(32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("t1_req", 64'(bus.imem_req), 64'd1);
    chk("t1_addr", 64'(bus.imem_addr), 64'd0);
    chk("t1_valid0", 64'(bus.instr_valid), 64'd0);
    tick(32'h0, 1'b0, 1'b1, 32'h20080005, 1'b1);
    chk("t1_valid", 64'(bus.instr_valid), 64'd1);
    chk("t1_instr", 64'(bus.instr), 64'h20080005);
    chk("t1_ipc", 64'(bus.instr_pc), 64'd0);
    chk("t1_cnt", 64'(fetch_count), 64'd1);
    tick(32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick(32'h0, 1'b0, 1'b1, 32'h20080005, 1'b1);
    tick(32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("t1_flushed", 64'(bus.instr_valid), 64'd0);

    // Buffer fills with decode stalled, then drains in order.
    tick(32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(32'h4, 1'b0, 1'b1, 32'hAAAA0001, 1'b0);
    tick(32'h4, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(32'h8, 1'b0, 1'b1, 32'hBBBB0002, 1'b0);
    chk("t2_stall_full", 64'(pc_stall), 64'd1);
    tick(32'h8, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t2_no_req", 64'(bus.imem_req), 64'd0);
    chk("t2_head0", 64'(bus.instr_pc), 64'd0);
    tick(32'h8, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("t2_head4", 64'(bus.instr_pc), 64'd4);
    chk("t2_instr4", 64'(bus.instr), 64'hBBBB0002);
    chk("t2_req_held", 64'(bus.imem_req), 64'd0);
    tick(32'h8, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("t2_req8", 64'(bus.imem_addr), 64'd8);
    chk("t2_empty", 64'(bus.instr_valid), 64'd0);
    tick(32'h8, 1'b0, 1'b1, 32'hCCCC0003, 1'b0);
    tick(32'h8, 1'b1, 1'b0, 32'h0, 1'b0);

    // Flush while waiting, ack three cycles after request.
    tick(32'h10, 1'b0, 1'b0, 32'h0, 1'b1);
    tick(32'h10, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("t3_req_held", 64'(bus.imem_req), 64'd1);
    chk("t3_addr_held", 64'(bus.imem_addr), 64'h10);
    chk("t3_stall", 64'(pc_stall), 64'd1);
    tick(32'h10, 1'b0, 1'b0, 32'h0, 1'b1);
    tick(32'h10, 1'b0, 1'b1, 32'hDDDD0004, 1'b1);
    chk("t3_valid", 64'(bus.instr_valid), 64'd0);
    chk("t3_cnt", 64'(fetch_count), 64'd5);
    chk("t3_stall_idle", 64'(pc_stall), 64'd0);

    // Flush coincident with ack.
    tick(32'h10, 1'b0, 1'b0, 32'h0, 1'b1);
    tick(32'h10, 1'b1, 1'b1, 32'hEEEE0005, 1'b1);
    chk("t4_valid", 64'(bus.instr_valid), 64'd0);
    chk("t4_cnt", 64'(fetch_count), 64'd5);
    chk("t4_req", 64'(bus.imem_req), 64'd0);

    // Misaligned PC.
    tick(32'h6, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("t5_mis", 64'(misalign_err), 64'd1);
    chk("t5_req", 64'(bus.imem_req), 64'd0);
    tick(32'h6, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("t5_mis_pulse", 64'(misalign_err), 64'd0);

    // Reset during an outstanding request.
    tick(32'h30, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("t6_req", 64'(bus.imem_req), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    model_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick(32'h32, 1'b0, 1'b1, 32'hFFFF0006, 1'b1);
    chk("t6_no_push", 64'(bus.instr_valid), 64'd0);
    chk("t6_cnt", 64'(fetch_count), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rpc  = {$urandom_range(0, 255) == 0 ? 30'd0 : 30'($urandom_range(0, 1023)), 2'b00};
      if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      rack = m_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      tick(rpc, $urandom_range(0, 9) == 0, rack, $urandom, $urandom_range(0, 1) == 1);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
